// File: rtl/seq_pkg.sv
// Shared definitions for the 1010 pattern generator and its matching detectors.
package seq_pkg;

  localparam int unsigned DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1010;
  localparam int unsigned DEF_OVL_LEN = 2;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/seq_gen_ctr.sv
// Bit pointer and repetition counter for the pattern generator.
// The pointer holds the pattern index currently on the serial output. bit_c is
// the pattern bit at the index the pointer will hold after this cycle's command.
module seq_gen_ctr
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned OVL_LEN = DEF_OVL_LEN,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [CNT_W-1:0] count,
  input  logic             ovl,
  output logic             last_bit,
  output logic             last_rep,
  output logic             bit_c
);

  localparam int unsigned PTR_W = $clog2(PAT_W);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PAT_W - 1);
  localparam logic [PTR_W-1:0] PTR_OVL = PTR_W'(OVL_LEN);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_d;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_d;
  logic             ovl_q;
  logic             ovl_d;

  // Next pointer/counter: load on burst start, advance on each unstalled bit.
  always_comb begin
    ptr_d = ptr;
    rem_d = rem;
    ovl_d = ovl_q;
    if (load) begin
      ptr_d = '0;
      rem_d = (count != '0) ? count - CNT_W'(1) : '0;
      ovl_d = ovl;
    end else if (step) begin
      if (last_bit) begin
        ptr_d = ovl_q ? PTR_OVL : '0;
        if (rem != '0) begin
          rem_d = rem - CNT_W'(1);
        end
      end else begin
        ptr_d = ptr + PTR_W'(1);
      end
    end
  end

  assign bit_c = PATTERN[PTR_LAST - ptr_d];

  // Counter registers plus registered end-of-pattern / end-of-burst flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      rem      <= '0;
      ovl_q    <= 1'b0;
      last_bit <= 1'b0;
      last_rep <= 1'b1;
    end else begin
      ptr      <= ptr_d;
      rem      <= rem_d;
      ovl_q    <= ovl_d;
      last_bit <= (ptr_d == PTR_LAST);
      last_rep <= (rem_d == '0);
    end
  end

endmodule

// File: rtl/seq_gen_1010.sv
// Serial pattern transmitter: bursts of repeated (optionally overlapping)
// pattern occurrences, MSB first, with an expected-detection strobe timed like
// a Moore detector's output.
module seq_gen_1010
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned OVL_LEN = DEF_OVL_LEN,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             ovl,
  input  logic             stall,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             det_exp
);

  state_t state;
  state_t state_d;
  logic   x_d;
  logic   x_valid_d;
  logic   busy_d;
  logic   done_d;
  logic   det_d;
  logic   ld_c;
  logic   step_c;
  logic   last_bit;
  logic   last_rep;
  logic   bit_c;

  seq_gen_ctr #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .OVL_LEN(OVL_LEN),
    .CNT_W  (CNT_W)
  ) u_ctr (
    .clk     (clk),
    .rst     (rst),
    .load    (ld_c),
    .step    (step_c),
    .count   (count),
    .ovl     (ovl),
    .last_bit(last_bit),
    .last_rep(last_rep),
    .bit_c   (bit_c)
  );

  // Next state and next output values.
  always_comb begin
    state_d   = state;
    x_d       = x;
    x_valid_d = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    det_d     = 1'b0;
    ld_c      = 1'b0;
    step_c    = 1'b0;
    case (state)
      IDLE: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (count != '0) begin
            ld_c      = 1'b1;
            state_d   = FIRST;
            x_d       = bit_c;
            x_valid_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      FIRST, REPEAT: begin
        // Strobe follows the valid cycle that carried an occurrence's last bit.
        det_d = x_valid && last_bit;
        if (stall) begin
          x_valid_d = 1'b0;
        end else if (last_bit && last_rep) begin
          state_d = DONE;
          x_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          step_c    = 1'b1;
          x_d       = bit_c;
          x_valid_d = 1'b1;
          if (last_bit) begin
            state_d = REPEAT;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        x_d     = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        x_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      det_exp <= 1'b0;
    end else begin
      state   <= state_d;
      x       <= x_d;
      x_valid <= x_valid_d;
      busy    <= busy_d;
      done    <= done_d;
      det_exp <= det_d;
    end
  end

endmodule

// File: tb/tb_seq_gen_1010.sv
// Directed bench for seq_gen_1010: per-cycle expected waveforms written by hand.
module tb_seq_gen_1010;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       ovl;
  logic       stall;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;
  logic       det_exp;

  int n_checks;
  int n_fail;

  seq_gen_1010 dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .count  (count),
    .ovl    (ovl),
    .stall  (stall),
    .x      (x),
    .x_valid(x_valid),
    .busy   (busy),
    .done   (done),
    .det_exp(det_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Start a burst in cycle 0, then check cycles 1..16. Vector bit [16-c] is cycle c.
  task automatic run_burst(input string tag, input logic [7:0] cnt, input logic ov,
                           input logic [15:0] stl, input logic [15:0] stm,
                           input logic [15:0] xe, input logic [15:0] xve,
                           input logic [15:0] be, input logic [15:0] de,
                           input logic [15:0] dte);
    start = 1'b1;
    count = cnt;
    ovl   = ov;
    stall = 1'b0;
    tick();
    for (int c = 1; c <= 16; c++) begin
      chk({tag, ".x"},       c, x,       xe[16-c]);
      chk({tag, ".x_valid"}, c, x_valid, xve[16-c]);
      chk({tag, ".busy"},    c, busy,    be[16-c]);
      chk({tag, ".done"},    c, done,    de[16-c]);
      chk({tag, ".det_exp"}, c, det_exp, dte[16-c]);
      start = stm[16-c];
      stall = stl[16-c];
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b0;
    start = 1'b0;
    count = 8'd0;
    ovl   = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    chk("rst.x",       0, x,       1'b0);
    chk("rst.x_valid", 0, x_valid, 1'b0);
    chk("rst.busy",    0, busy,    1'b0);
    chk("rst.done",    0, done,    1'b0);
    chk("rst.det_exp", 0, det_exp, 1'b0);
    rst = 1'b1;
    tick();
    chk("idle.busy", 0, busy, 1'b0);

    // count=1, no overlap; stall while DONE/IDLE must not matter.
    run_burst("c1_novl", 8'd1, 1'b0,
              16'b0000_1110_0000_0000, 16'b0,
              16'b1010_0000_0000_0000, 16'b1111_0000_0000_0000,
              16'b1111_0000_0000_0000, 16'b0000_1000_0000_0000,
              16'b0000_1000_0000_0000);

    // count=3, overlapping repeats share "10".
    run_burst("c3_ovl", 8'd3, 1'b1, 16'b0, 16'b0,
              16'b1010_1010_0000_0000, 16'b1111_1111_0000_0000,
              16'b1111_1111_0000_0000, 16'b0000_0000_1000_0000,
              16'b0000_1010_1000_0000);

    // count=3, full repeats.
    run_burst("c3_novl", 8'd3, 1'b0, 16'b0, 16'b0,
              16'b1010_1010_1010_0000, 16'b1111_1111_1111_0000,
              16'b1111_1111_1111_0000, 16'b0000_0000_0000_1000,
              16'b0000_1000_1000_1000);

    // count=0: done and busy in cycle 1 only, no bits.
    run_burst("c0", 8'd0, 1'b0, 16'b0, 16'b0,
              16'b0, 16'b0,
              16'b1000_0000_0000_0000, 16'b1000_0000_0000_0000,
              16'b0);

    // count=2 with stall high in cycles 2-3.
    run_burst("c2_stall", 8'd2, 1'b0,
              16'b0110_0000_0000_0000, 16'b0,
              16'b1000_1010_1000_0000, 16'b1100_1111_1100_0000,
              16'b1111_1111_1100_0000, 16'b0000_0000_0010_0000,
              16'b0000_0010_0010_0000);

    // count=2 with start pulses in cycles 2 and 5 that must be ignored.
    run_burst("c2_startig", 8'd2, 1'b0,
              16'b0, 16'b0100_1000_0000_0000,
              16'b1010_1010_0000_0000, 16'b1111_1111_0000_0000,
              16'b1111_1111_0000_0000, 16'b0000_0000_1000_0000,
              16'b0000_1000_1000_0000);

    // Reset in cycle 3 of a count=2 burst abandons it without done.
    start = 1'b1;
    count = 8'd2;
    ovl   = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid.busy",    3, busy,    1'b1);
    chk("mid.x_valid", 3, x_valid, 1'b1);
    chk("mid.x",       3, x,       1'b1);
    rst = 1'b0;
    #1;
    chk("arst.x",       3, x,       1'b0);
    chk("arst.x_valid", 3, x_valid, 1'b0);
    chk("arst.busy",    3, busy,    1'b0);
    chk("arst.done",    3, done,    1'b0);
    chk("arst.det_exp", 3, det_exp, 1'b0);
    for (int c = 4; c <= 5; c++) begin
      tick();
      chk("arst_hold.done", c, done, 1'b0);
      chk("arst_hold.busy", c, busy, 1'b0);
    end
    rst = 1'b1;
    for (int c = 6; c <= 8; c++) begin
      tick();
      chk("post_rst.done",    c, done,    1'b0);
      chk("post_rst.x_valid", c, x_valid, 1'b0);
    end

    // Fresh burst after reset restarts from the pattern MSB.
    run_burst("after_rst", 8'd1, 1'b0, 16'b0, 16'b0,
              16'b1010_0000_0000_0000, 16'b1111_0000_0000_0000,
              16'b1111_0000_0000_0000, 16'b0000_1000_0000_0000,
              16'b0000_1000_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
